// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit: operation codes and FSM states.
// Rotate operations (SHIFT_OP_ROR / SHIFT_OP_ROL) are only implemented when
// the build defines SHIFT_UNIT_ROTATE_EN; otherwise they act as reserved codes.
package shift_pkg;

   // Operation codes carried on in_op; values 101..111 are reserved.
   typedef enum logic [2:0] {
      SHIFT_OP_LSL = 3'b000,
      SHIFT_OP_LSR = 3'b001,
      SHIFT_OP_ASR = 3'b010,
      SHIFT_OP_ROR = 3'b011,
      SHIFT_OP_ROL = 3'b100
   } shift_op_e;

   // Control FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } shift_state_e;

   // True when the op code selects an implemented operation in this build.
   function automatic logic op_is_active(input logic [2:0] op);
      logic active;
      case (op)
         SHIFT_OP_LSL: active = 1'b1;
         SHIFT_OP_LSR: active = 1'b1;
         SHIFT_OP_ASR: active = 1'b1;
`ifdef SHIFT_UNIT_ROTATE_EN
         SHIFT_OP_ROR: active = 1'b1;
         SHIFT_OP_ROL: active = 1'b1;
`endif
         default:      active = 1'b0;
      endcase
      return active;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel stage: shifts or rotates the operand by the fixed distance DIST
// when enabled, otherwise passes it through. Purely combinational.
// Rotate paths exist only when SHIFT_UNIT_ROTATE_EN is defined.
module shift_stage
   import shift_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [2:0]       op_i,
   input  logic             fill_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] data_o
);

   // Select the shifted/rotated form of the operand for this stage distance.
   always_comb begin
      data_o = data_i;
      if (en_i && op_is_active(op_i)) begin
         case (op_i)
            SHIFT_OP_LSL: data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
            SHIFT_OP_LSR: data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
            SHIFT_OP_ASR: data_o = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
`ifdef SHIFT_UNIT_ROTATE_EN
            SHIFT_OP_ROR: data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
            SHIFT_OP_ROL: data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
`endif
            default:      data_o = data_i;
         endcase
      end else begin
         data_o = data_i;
      end
   end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle barrel shifter with valid/ready handshakes. A request is
// captured in IDLE, one barrel stage (distance 2^k) is applied per cycle in
// BUSY, and the result is held in DONE until the consumer takes it.
// Latency is always AW cycles from accept to out_valid, whatever the amount.
// Build option: SHIFT_UNIT_ROTATE_EN enables ROR/ROL; without it those codes
// are pass-through like the other reserved codes.
module shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [$clog2(WIDTH)-1:0]   in_amount,
   input  logic [2:0]                 in_op,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_carry,
   output logic                       out_zero,
   output logic                       out_neg
);

   localparam int AW = $clog2(WIDTH);
   // Stage counter only needs to count 0..AW-1.
   localparam int SW = (AW > 1) ? $clog2(AW) : 1;
   localparam logic [SW-1:0] LAST_STAGE = SW'(AW - 1);

   shift_state_e       state_q,     state_d;
   logic [SW-1:0]      stage_q,     stage_d;
   logic [WIDTH-1:0]   work_q,      work_d;
   logic [AW-1:0]      amount_q,    amount_d;
   logic [2:0]         op_q,        op_d;
   logic               fill_q,      fill_d;
   logic               carry_q,     carry_d;
   logic [WIDTH-1:0]   out_data_q,  out_data_d;
   logic               out_carry_q, out_carry_d;

   logic [WIDTH-1:0]   stage_out_s [AW];
   logic [WIDTH-1:0]   stage_sel_s;
   logic [AW-1:0]      lsl_idx_s;
   logic [AW-1:0]      rsh_idx_s;
   logic               accept_carry_s;

   // All barrel stages see the working operand; each is enabled by its own
   // amount bit, and the stage counter picks which one lands this cycle.
   for (genvar k = 0; k < AW; k++) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << k)
      ) u_stage (
         .data_i (work_q),
         .op_i   (op_q),
         .fill_i (fill_q),
         .en_i   (amount_q[k]),
         .data_o (stage_out_s[k])
      );
   end

   // Route the output of the stage addressed by the stage counter.
   always_comb begin
      stage_sel_s = work_q;
      for (int k = 0; k < AW; k++) begin
         stage_sel_s = (stage_q == SW'(k)) ? stage_out_s[k] : stage_sel_s;
      end
   end

   // Carry is fully determined by the request, so it is resolved at accept.
   // WIDTH-amount wraps naturally in AW bits because amount is never 0 here.
   always_comb begin
      lsl_idx_s      = {AW{1'b0}} - in_amount;
      rsh_idx_s      = in_amount - {{(AW-1){1'b0}}, 1'b1};
      accept_carry_s = 1'b0;
      if (in_amount == {AW{1'b0}}) begin
         accept_carry_s = 1'b0;
      end else begin
         case (in_op)
            SHIFT_OP_LSL: accept_carry_s = in_data[lsl_idx_s];
            SHIFT_OP_LSR: accept_carry_s = in_data[rsh_idx_s];
            SHIFT_OP_ASR: accept_carry_s = in_data[rsh_idx_s];
`ifdef SHIFT_UNIT_ROTATE_EN
            SHIFT_OP_ROR: accept_carry_s = in_data[rsh_idx_s];
            SHIFT_OP_ROL: accept_carry_s = in_data[lsl_idx_s];
`endif
            default:      accept_carry_s = 1'b0;
         endcase
      end
   end

   // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      work_d      = work_q;
      amount_d    = amount_q;
      op_d        = op_q;
      fill_d      = fill_q;
      carry_d     = carry_q;
      out_data_d  = out_data_q;
      out_carry_d = out_carry_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               work_d   = in_data;
               amount_d = in_amount;
               op_d     = in_op;
               fill_d   = in_data[WIDTH-1];
               carry_d  = accept_carry_s;
               stage_d  = {SW{1'b0}};
               state_d  = ST_BUSY;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_BUSY: begin
            work_d = stage_sel_s;
            if (stage_q == LAST_STAGE) begin
               out_data_d  = stage_sel_s;
               out_carry_d = carry_q;
               stage_d     = {SW{1'b0}};
               state_d     = ST_DONE;
            end else begin
               stage_d     = stage_q + SW'(1);
               state_d     = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            stage_d = {SW{1'b0}};
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         stage_q     <= {SW{1'b0}};
         work_q      <= {WIDTH{1'b0}};
         amount_q    <= {AW{1'b0}};
         op_q        <= 3'b000;
         fill_q      <= 1'b0;
         carry_q     <= 1'b0;
         out_data_q  <= {WIDTH{1'b0}};
         out_carry_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         stage_q     <= stage_d;
         work_q      <= work_d;
         amount_q    <= amount_d;
         op_q        <= op_d;
         fill_q      <= fill_d;
         carry_q     <= carry_d;
         out_data_q  <= out_data_d;
         out_carry_q <= out_carry_d;
      end
   end

   // Handshake and flags are decoded straight from registered state/result.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_data  = out_data_q;
   assign out_carry = out_carry_q;
   assign out_zero  = (out_data_q == {WIDTH{1'b0}});
   assign out_neg   = out_data_q[WIDTH-1];

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit at WIDTH=16: directed vector table,
// handshake stall and mid-operation reset sequences, then random requests
// compared with an arithmetic reference model. Honours SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit;

   localparam int WIDTH = 16;
   localparam int AW    = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data = 16'h0000;
   logic [AW-1:0]     in_amount = 4'h0;
   logic [2:0]        in_op = 3'b000;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [WIDTH-1:0]  out_data;
   logic              out_carry;
   logic              out_zero;
   logic              out_neg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amount (in_amount),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry),
      .out_zero  (out_zero),
      .out_neg   (out_neg)
   );

   typedef struct {
      logic [2:0]  op;
      logic [15:0] data;
      logic [3:0]  amt;
      logic [15:0] exp_data;
      logic        exp_carry;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add_vec(input logic [2:0] op, input logic [15:0] d,
                                   input logic [3:0] a, input logic [15:0] r, input logic c);
      vec_t v;
      v.op = op; v.data = d; v.amt = a; v.exp_data = r; v.exp_carry = c;
      vecs.push_back(v);
   endfunction

   // Reference: whole-word arithmetic on the request, no stage decomposition.
   function automatic void model(input logic [2:0] op, input logic [15:0] d, input logic [3:0] a,
                                 output logic [15:0] r, output logic c);
      int n;
      logic [31:0] dd;
      n  = int'(a);
      dd = {d, d};
      r  = d;
      c  = 1'b0;
      case (op)
         3'd0: begin
            r = 16'(32'(d) << n);
            if (n != 0) c = d[16 - n];
         end
         3'd1: begin
            r = d >> n;
            if (n != 0) c = d[n - 1];
         end
         3'd2: begin
            r = 16'($signed(d) >>> n);
            if (n != 0) c = d[n - 1];
         end
`ifdef SHIFT_UNIT_ROTATE_EN
         3'd3: begin
            r = 16'(dd >> n);
            if (n != 0) c = d[n - 1];
         end
         4'd4: begin
            r = 16'((dd << n) >> 16);
            if (n != 0) c = d[16 - n];
         end
`endif
         default: begin
            r = d;
            c = 1'b0;
         end
      endcase
   endfunction

   // Issue one request, hold the result for 'stall' cycles, check it, take it.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] d,
                         input logic [3:0] a, input logic [15:0] er, input logic ec, input int stall);
      int lat;
      chk({tag, ".ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_op = op; in_data = d; in_amount = a;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_data   = 16'($urandom);
      in_amount = 4'($urandom);
      in_op     = 3'($urandom);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'd4);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
      end
      chk({tag, ".data"},  32'(out_data),  32'(er));
      chk({tag, ".carry"}, 32'(out_carry), 32'(ec));
      chk({tag, ".zero"},  32'(out_zero),  32'(er == 16'h0000));
      chk({tag, ".neg"},   32'(out_neg),   32'(er[15]));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [15:0] r;
      logic        c;
      logic [2:0]  op;
      logic [15:0] d;
      logic [3:0]  a;
      int          lat;
      logic        seen;

      // Directed table.
      add_vec(3'b001, 16'h000B, 4'd1,  16'h0005, 1'b1);
      add_vec(3'b010, 16'h8F00, 4'd4,  16'hF8F0, 1'b0);
      add_vec(3'b010, 16'h8001, 4'd15, 16'hFFFF, 1'b0);
      add_vec(3'b000, 16'h8001, 4'd1,  16'h0002, 1'b1);
      add_vec(3'b000, 16'h0030, 4'd15, 16'h0000, 1'b0);
      add_vec(3'b001, 16'h1234, 4'd0,  16'h1234, 1'b0);
      add_vec(3'b101, 16'hABCD, 4'd3,  16'hABCD, 1'b0);
      add_vec(3'b111, 16'h0000, 4'd7,  16'h0000, 1'b0);
`ifdef SHIFT_UNIT_ROTATE_EN
      add_vec(3'b011, 16'h0001, 4'd1,  16'h8000, 1'b1);
      add_vec(3'b100, 16'h8000, 4'd1,  16'h0001, 1'b1);
`else
      add_vec(3'b011, 16'h0001, 4'd1,  16'h0001, 1'b0);
      add_vec(3'b100, 16'h8000, 4'd1,  16'h8000, 1'b0);
`endif

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst.ready", 32'(in_ready),  32'd1);
      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.data",  32'(out_data),  32'd0);
      chk("rst.carry", 32'(out_carry), 32'd0);
      chk("rst.zero",  32'(out_zero),  32'd1);
      chk("rst.neg",   32'(out_neg),   32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].amt,
                vecs[i].exp_data, vecs[i].exp_carry, i % 2);
      end

      // Consumer stalls 5 cycles while a new request is offered.
      in_valid = 1'b1; in_op = 3'b000; in_data = 16'h00F0; in_amount = 4'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("stall.latency", 32'(lat), 32'd4);
      for (int s = 0; s < 5; s++) begin
         in_valid = 1'b1; in_op = 3'b001; in_data = 16'hFFFF; in_amount = 4'd1;
         chk("stall.valid", 32'(out_valid), 32'd1);
         chk("stall.ready", 32'(in_ready),  32'd0);
         chk("stall.data",  32'(out_data),  32'h03C0);
         chk("stall.carry", 32'(out_carry), 32'd0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("stall.after_valid", 32'(out_valid), 32'd0);
      chk("stall.after_ready", 32'(in_ready),  32'd1);
      seen = 1'b0;
      for (int s = 0; s < 6; s++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      chk("stall.no_ghost", 32'(seen), 32'd0);

      // Reset pulsed while BUSY aborts the operation.
      in_valid = 1'b1; in_op = 3'b000; in_data = 16'h1111; in_amount = 4'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("abort.ready", 32'(in_ready),  32'd1);
      chk("abort.valid", 32'(out_valid), 32'd0);
      chk("abort.data",  32'(out_data),  32'd0);
      chk("abort.carry", 32'(out_carry), 32'd0);
      chk("abort.zero",  32'(out_zero),  32'd1);
      chk("abort.neg",   32'(out_neg),   32'd0);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      for (int s = 0; s < 8; s++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      chk("abort.no_result", 32'(seen), 32'd0);

      // Random requests against the reference model.
      for (int i = 0; i < 250; i++) begin
         op = 3'($urandom_range(0, 7));
         d  = 16'($urandom);
         a  = 4'($urandom);
         model(op, d, a, r, c);
         run_op($sformatf("rnd%0d op%0d d%h a%0d", i, op, d, a), op, d, a, r, c,
                int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
